// File: rtl/cpu_pkg.sv
//----------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the multiply/divide unit.
//   mdu_op_t    : operation select (MUL / DIV)
//   mdu_state_t : control FSM state encoding
//   MDU_ITERS   : shift iterations per operation (one per operand bit)
//----------------------------------------------------------------------------
`timescale 1ns/1ps
package cpu_pkg;

   typedef enum logic {
      MDU_MUL = 1'b0,
      MDU_DIV = 1'b1
   } mdu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mdu_state_t;

   localparam int unsigned MDU_ITERS = 16;

endpackage

// File: rtl/mdu_step.sv
//----------------------------------------------------------------------------
// mdu_step
// One combinational iteration of the unsigned multiply/divide datapath.
//   op       : MDU_MUL = shift-add, MDU_DIV = restoring shift-subtract
//   acc      : working register. MUL: {partial high, multiplier/low product}
//              DIV: {partial remainder, dividend/quotient}
//   m        : multiplicand (MUL) or divisor (DIV) magnitude
//   acc_next : working register after this iteration
//----------------------------------------------------------------------------
`timescale 1ns/1ps
module mdu_step
   import cpu_pkg::*;
(
   input  mdu_op_t     op,
   input  logic [31:0] acc,
   input  logic [15:0] m,
   output logic [31:0] acc_next
);

   logic [16:0] sum;
   logic [32:0] sh;
   logic [15:0] diff;
   logic        ge;

   always_comb begin
      // MUL: add multiplicand into high half when multiplier lsb is set,
      // then shift the whole {carry, high, low} right by one.
      sum  = {1'b0, acc[31:16]} + (acc[0] ? {1'b0, m} : 17'd0);
      // DIV: shift {rem, quot} left; try subtracting the divisor.
      sh   = {1'b0, acc, 1'b0} >> 1;
      sh   = {acc, 1'b0};
      ge   = (sh[32:16] >= {1'b0, m});
      // When ge holds the true difference is below m, so 16 bits suffice.
      diff = sh[31:16] - m;
      acc_next = acc;
      if (op == MDU_MUL) begin
         acc_next = {sum, acc[15:1]};
      end else if (ge) begin
         acc_next = {diff, sh[15:1], 1'b1};
      end else begin
         acc_next = sh[31:0];
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
//----------------------------------------------------------------------------
// mul_div_unit
// Iterative signed 16x16 multiplier / 16/16 divider with register-file
// write-back strobes.
//   clk, rst        : clock, asynchronous active-low reset
//   halt_sys        : synchronous freeze of all state
//   start, op       : request, MDU_MUL / MDU_DIV
//   operand_a/b     : multiplicand/dividend, multiplier/divisor
//   dest_addr       : destination register of the low result half
//   busy, done      : CALC or DONE / one-cycle result strobe
//   write_data      : {high, low} result, held between operations
//   write_en, R0_en : write strobes (equal to done)
//   write_address   : destination of the last result
//   div_by_zero     : last accepted DIV had a zero divisor
//   fsm_state       : current control state (debug visibility)
//
// Handshake: start is taken on a rising edge only when the unit is IDLE and
// halt_sys=0; requests at other times are dropped, not queued. done is high
// exactly while the FSM sits in DONE, and write_data/write_address are valid
// whenever done=1.
//----------------------------------------------------------------------------
`timescale 1ns/1ps
module mul_div_unit
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        halt_sys,
   input  logic        start,
   input  logic        op,
   input  logic [15:0] operand_a,
   input  logic [15:0] operand_b,
   input  logic [3:0]  dest_addr,
   output logic        busy,
   output logic        done,
   output logic [31:0] write_data,
   output logic        write_en,
   output logic        R0_en,
   output logic [3:0]  write_address,
   output logic        div_by_zero,
   output mdu_state_t  fsm_state
);

   mdu_state_t  state, state_next;
   logic        accept, calc_step, calc_end, dbz_now;
   logic [4:0]  cnt;
   mdu_op_t     op_q;
   logic [3:0]  dest_q;
   logic        sign_q, sign_r;
   logic [31:0] acc, acc_next, mul_fix, result;
   logic [15:0] m_q, abs_a, abs_b, quot_fix, rem_fix;

   assign abs_a   = operand_a[15] ? -operand_a : operand_a;
   assign abs_b   = operand_b[15] ? -operand_b : operand_b;
   assign dbz_now = (mdu_op_t'(op) == MDU_DIV) && (operand_b == 16'd0);

   // Control FSM: next state and step qualifiers. halt_sys suppresses all.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      calc_step  = 1'b0;
      calc_end   = 1'b0;
      if (!halt_sys) begin
         case (state)
            IDLE: if (start) begin
               accept     = 1'b1;
               state_next = dbz_now ? DONE : CALC;
            end
            CALC: if (cnt == 5'(MDU_ITERS)) begin
               // Extra cycle after the last iteration applies sign fix-up.
               calc_end   = 1'b1;
               state_next = DONE;
            end else begin
               calc_step  = 1'b1;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   mdu_step u_step (
      .op       (op_q),
      .acc      (acc),
      .m        (m_q),
      .acc_next (acc_next)
   );

   // Sign fix-up of the unsigned magnitudes.
   assign mul_fix  = sign_q ? -acc : acc;
   assign quot_fix = sign_q ? -acc[15:0] : acc[15:0];
   assign rem_fix  = sign_r ? -acc[31:16] : acc[31:16];
   assign result   = (op_q == MDU_MUL) ? mul_fix : {rem_fix, quot_fix};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt           <= 5'd0;
         op_q          <= MDU_MUL;
         dest_q        <= 4'd0;
         sign_q        <= 1'b0;
         sign_r        <= 1'b0;
         acc           <= 32'd0;
         m_q           <= 16'd0;
         write_data    <= 32'd0;
         write_address <= 4'd0;
         div_by_zero   <= 1'b0;
      end else if (accept) begin
         cnt         <= 5'd0;
         op_q        <= mdu_op_t'(op);
         dest_q      <= dest_addr;
         sign_q      <= operand_a[15] ^ operand_b[15];
         sign_r      <= operand_a[15];
         div_by_zero <= dbz_now;
         // MUL iterates over the multiplier bits; DIV over the dividend bits.
         acc <= {16'd0, (mdu_op_t'(op) == MDU_DIV) ? abs_a : abs_b};
         m_q <= (mdu_op_t'(op) == MDU_DIV) ? abs_b : abs_a;
         if (dbz_now) begin
            write_data    <= {operand_a, 16'hFFFF};
            write_address <= dest_addr;
         end
      end else if (calc_step) begin
         acc <= acc_next;
         cnt <= cnt + 5'd1;
      end else if (calc_end) begin
         write_data    <= result;
         write_address <= dest_q;
      end
   end

   assign fsm_state = state;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign write_en  = done;
   assign R0_en     = done;

endmodule

// File: tb/tb_mul_div_unit.sv
//----------------------------------------------------------------------------
// tb_mul_div_unit
// Directed self-checking bench for mul_div_unit with hand-computed results.
//----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mul_div_unit;
   import cpu_pkg::*;

   // clock / reset
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        halt_sys = 1'b0;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic [15:0] operand_a = 16'd0;
   logic [15:0] operand_b = 16'd0;
   logic [3:0]  dest_addr = 4'd0;
   logic        busy, done, write_en, R0_en, div_by_zero;
   logic [31:0] write_data;
   logic [3:0]  write_address;
   mdu_state_t  fsm_state;

   int checks = 0;
   int errors = 0;
   int cyc;
   logic seen;

   always #5 clk = ~clk;

   mul_div_unit dut (
      .clk           (clk),
      .rst           (rst),
      .halt_sys      (halt_sys),
      .start         (start),
      .op            (op),
      .operand_a     (operand_a),
      .operand_b     (operand_b),
      .dest_addr     (dest_addr),
      .busy          (busy),
      .done          (done),
      .write_data    (write_data),
      .write_en      (write_en),
      .R0_en         (R0_en),
      .write_address (write_address),
      .div_by_zero   (div_by_zero),
      .fsm_state     (fsm_state)
   );

   // scoreboard check
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // driver: request accepted on the next rising edge; inputs are then
   // scrambled so the operation in flight must rely on its latched copies.
   task automatic start_op(input logic o, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] d);
      @(negedge clk);
      op = o; operand_a = a; operand_b = b; dest_addr = d; start = 1'b1;
      @(posedge clk);
      #1;
      start     = 1'b0;
      op        = ~o;
      operand_a = 16'($urandom_range(0, 65535));
      operand_b = 16'($urandom_range(0, 65535));
      dest_addr = 4'($urandom_range(0, 15));
   endtask

   // Count cycles after the acceptance edge until done; optional 3-cycle halt.
   task automatic wait_done(input int halt_at, output int n);
      n = 0;
      while (n < 60) begin
         @(negedge clk);
         n++;
         if (done === 1'b1) break;
         if (halt_at != 0 && n == halt_at)     halt_sys = 1'b1;
         if (halt_at != 0 && n == halt_at + 3) halt_sys = 1'b0;
      end
   endtask

   task automatic check_result(input string tag, input logic [31:0] exp_data,
                               input logic [3:0] exp_addr, input int exp_cyc, input int n);
      chk({tag, "_lat"},   32'(n), 32'(exp_cyc));
      chk({tag, "_done"},  {31'd0, done}, 32'd1);
      chk({tag, "_we"},    {30'd0, write_en, R0_en}, 32'd3);
      chk({tag, "_busy"},  {31'd0, busy}, 32'd1);
      chk({tag, "_data"},  write_data, exp_data);
      chk({tag, "_addr"},  {28'd0, write_address}, {28'd0, exp_addr});
      @(negedge clk);
      chk({tag, "_pulse"}, {29'd0, done, write_en, R0_en}, 32'd0);
      chk({tag, "_idle"},  {31'd0, busy}, 32'd0);
      chk({tag, "_hold"},  write_data, exp_data);
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      chk("rst_data",  write_data, 32'd0);
      chk("rst_addr",  {28'd0, write_address}, 32'd0);
      chk("rst_flags", {27'd0, busy, done, write_en, R0_en, div_by_zero}, 32'd0);
      chk("rst_state", 32'(fsm_state), 32'(IDLE));
      rst = 1'b1;

      // start together with halt in IDLE is not taken
      @(negedge clk);
      halt_sys = 1'b1; start = 1'b1; operand_a = 16'd3; operand_b = 16'd4;
      @(negedge clk);
      chk("halt_start_busy", {31'd0, busy}, 32'd0);
      start = 1'b0; halt_sys = 1'b0;

      start_op(1'b0, 16'h0003, 16'hFFFE, 4'h5);
      wait_done(0, cyc);
      check_result("mul_3_m2", 32'hFFFF_FFFA, 4'h5, 18, cyc);

      start_op(1'b1, 16'd100, 16'd7, 4'h6);
      wait_done(0, cyc);
      check_result("div_100_7", 32'h0002_000E, 4'h6, 18, cyc);

      start_op(1'b1, 16'hFFF9, 16'h0002, 4'h7);
      wait_done(0, cyc);
      check_result("div_m7_2", 32'hFFFF_FFFD, 4'h7, 18, cyc);

      start_op(1'b1, 16'h8000, 16'hFFFF, 4'h8);
      wait_done(0, cyc);
      chk("div_min_dbz", {31'd0, div_by_zero}, 32'd0);
      check_result("div_min_m1", 32'h0000_8000, 4'h8, 18, cyc);

      start_op(1'b0, 16'h8000, 16'h0002, 4'h1);
      wait_done(0, cyc);
      check_result("mul_min_2", 32'hFFFF_0000, 4'h1, 18, cyc);

      start_op(1'b1, 16'h1234, 16'h0000, 4'h2);
      wait_done(0, cyc);
      chk("dbz_set", {31'd0, div_by_zero}, 32'd1);
      check_result("div_zero", 32'h1234_FFFF, 4'h2, 1, cyc);
      chk("dbz_hold", {31'd0, div_by_zero}, 32'd1);

      // next MUL clears the flag; 3-cycle halt mid-CALC delays done by 3
      start_op(1'b0, 16'h7FFF, 16'h7FFF, 4'h3);
      chk("dbz_clear", {31'd0, div_by_zero}, 32'd0);
      wait_done(5, cyc);
      check_result("mul_halt", 32'h3FFF_0001, 4'h3, 21, cyc);

      // start pulses while busy are ignored; last result held during CALC
      start_op(1'b0, 16'h0012, 16'h0034, 4'h9);
      chk("calc_hold_data", write_data, 32'h3FFF_0001);
      chk("calc_hold_addr", {28'd0, write_address}, 32'h3);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         start = 1'b1; op = 1'($urandom_range(0, 1));
         operand_a = 16'($urandom_range(1, 65535));
         operand_b = 16'($urandom_range(1, 65535));
         dest_addr = 4'(k);
      end
      @(negedge clk);
      start = 1'b0;
      wait_done(0, cyc);
      check_result("busy_ign", 32'h0000_03A8, 4'h9, 13, cyc);
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done !== 1'b0) seen = 1'b1;
      end
      chk("busy_no_second", {31'd0, seen}, 32'd0);

      // halt in DONE holds the strobes
      start_op(1'b0, 16'hFFFF, 16'hFFFF, 4'hA);
      wait_done(0, cyc);
      chk("hdone_lat", 32'(cyc), 32'd18);
      chk("hdone_data", write_data, 32'h0000_0001);
      halt_sys = 1'b1;
      @(negedge clk);
      chk("hdone_hold1", {29'd0, done, write_en, R0_en}, 32'd7);
      @(negedge clk);
      chk("hdone_hold2", {29'd0, done, write_en, R0_en}, 32'd7);
      halt_sys = 1'b0;
      @(negedge clk);
      chk("hdone_release", {30'd0, done, busy}, 32'd0);

      // reset mid-DIV
      start_op(1'b1, 16'h7000, 16'h0003, 4'hB);
      repeat (8) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("arst_data",  write_data, 32'd0);
      chk("arst_addr",  {28'd0, write_address}, 32'd0);
      chk("arst_flags", {27'd0, busy, done, write_en, R0_en, div_by_zero}, 32'd0);
      chk("arst_state", 32'(fsm_state), 32'(IDLE));
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done !== 1'b0) seen = 1'b1;
      end
      rst = 1'b1;
      repeat (25) begin
         @(negedge clk);
         if (done !== 1'b0) seen = 1'b1;
      end
      chk("arst_no_done", {31'd0, seen}, 32'd0);

      start_op(1'b0, 16'd5, 16'd6, 4'hC);
      wait_done(0, cyc);
      check_result("mul_5_6", 32'h0000_001E, 4'hC, 18, cyc);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 clk  in  1  system clock; all state updates on its rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset; rst=0 clears all state immediately.
REQ-003 halt_sys  in  1  1 = freeze the FSM, counter, operands and outputs; no state changes.
REQ-004 start  in  1  request a new operation; accepted only in IDLE with halt_sys=0.
REQ-005 op  in  1  0 = MUL, 1 = DIV; both signed two's complement.
REQ-006 operand_a  in  16  multiplicand or dividend.
REQ-007 operand_b  in  16  multiplier or divisor.
REQ-008 dest_addr  in  4  destination register for the low result half.
REQ-009 busy  out  1  1 in CALC and DONE.
REQ-010 done  out  1  single-cycle pulse; result is valid in that cycle.
REQ-011 write_data  out  32  {high,low}. MUL gives {product[31:16], product[15:0]}; DIV gives {remainder, quotient}.
REQ-012 write_en  out  1  equals done; register-file write strobe.
REQ-013 R0_en  out  1  equals done; high half goes to R0.
REQ-014 write_address  out  4  dest_addr latched at start acceptance.
REQ-015 div_by_zero  out  1  set at acceptance of DIV with operand_b=0; cleared at the next accepted start.

Function
REQ-016 The FSM SHALL have three states: IDLE, CALC and DONE. Transitions: IDLE->CALC on accepted start; CALC->DONE after 16 iterations; DONE->IDLE unconditionally.
REQ-017 Acceptance SHALL latch op, dest_addr, |operand_a|, |operand_b| and the result signs, and SHALL clear the 5-bit iteration counter.
REQ-018 CALC SHALL perform one iteration per non-halted cycle: shift-add for MUL, restoring shift-subtract for DIV.
REQ-019 Latency SHALL be as follows: if start is accepted at edge N, done=1 during the cycle after edge N+17, provided there is no halt.
REQ-020 MUL sign SHALL be a[15]^b[15]; the 32-bit magnitude is negated when the sign is negative.
REQ-021 DIV SHALL truncate toward zero: the quotient sign is a[15]^b[15] and the remainder sign follows the dividend.
REQ-022 DIV of -32768 by -1 SHALL give quotient 16'h8000 and remainder 16'h0000, with no flag.
REQ-023 DIV with operand_b=0 SHALL go IDLE->DONE directly (done one cycle after acceptance) with write_data={operand_a, 16'hFFFF}.
REQ-024 start while busy=1 SHALL be ignored, with no effect on any state.
REQ-025 Simultaneous start and halt_sys=1 in IDLE: start is not accepted.
REQ-026 halt_sys=1 in DONE SHALL hold done, write_en and R0_en high until the halt is released; exactly one DONE cycle then elapses after release.
REQ-027 Outside DONE, write_data and write_address SHALL hold the last result; done, write_en and R0_en are 0.
REQ-028 operand_a, operand_b and op changes after acceptance SHALL NOT affect the result in progress.

Reset
REQ-029 rst=0 SHALL force IDLE and counter=0, and SHALL drive 0 on busy, done, write_en, R0_en, write_data, write_address and div_by_zero.
REQ-030 Reset during CALC or DONE SHALL abort the operation with no write strobe; the first accepted start after reset release begins normally.

Structure
REQ-031 Package cpu_pkg SHALL hold mdu_op_t (MDU_MUL=1'b0, MDU_DIV=1'b1), mdu_state_t (IDLE, CALC, DONE) and the constant MDU_ITERS=16.
REQ-032 One sub-module, mdu_step, SHALL be combinational and perform a single shift-add or shift-subtract iteration, selected by op; the FSM, counter and sign fix-up stay in mul_div_unit.
REQ-033 The block SHALL have no clock gating; halt_sys SHALL be used as a synchronous enable only.

Verification
REQ-034 MUL 16'h0003 x 16'hFFFE -> write_data=32'hFFFF_FFFA; done in the 18th cycle after the start edge; write_en=R0_en=1 for that one cycle.
REQ-035 DIV 100/7 -> 32'h0002_000E; DIV -7/2 -> 32'hFFFF_FFFD (quotient -3, remainder -1); DIV -32768/-1 -> 32'h0000_8000.
REQ-036 DIV 16'h1234/0 -> 32'h1234_FFFF, div_by_zero=1, done one cycle after acceptance; the next MUL clears div_by_zero.
REQ-037 MUL 16'h7FFF x 16'h7FFF with halt_sys=1 for 3 cycles mid-CALC -> done delayed by exactly 3 cycles; result 32'h3FFF_0001.
REQ-038 start pulsed repeatedly with different operands while busy -> only the first operation completes, with its original result and write_address.
REQ-039 rst=0 asserted at iteration 8 of a DIV -> all outputs 0 immediately and no done pulse; after release, MUL 5 x 6 -> 32'h0000_001E.
